// File: rtl/sobel_window_gen.sv
// 3x3 sliding-window generator for a Sobel core: two line buffers plus a 3x3 shift window.
// Define SOBEL_WIN_EOL_CHECK_EN to compile in s_eol checking (sticky err_eol, s_eol forces a line wrap).
module sobel_window_gen #(
  parameter int DATA_W    = 8,
  parameter int MAX_WIDTH = 1024,
  parameter int CNT_W     = 11
) (
  input  logic                  s00_axi_aclk,
  input  logic                  s00_axi_aresetn,
  input  logic [CNT_W-1:0]      line_width,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_W-1:0]     s_data,
  input  logic                  s_sof,
  input  logic                  s_eol,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [9*DATA_W-1:0]   m_window,
  output logic                  m_eol,
  output logic                  err_eol
);

  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     col_q, col_d;
  logic [1:0]           row_q, row_d;
  logic [CNT_W-1:0]     w_q, w_d;
  logic                 m_valid_q, m_valid_d;
  logic                 m_eol_q, m_eol_d;
  logic [9*DATA_W-1:0]  m_window_q, m_window_d;
  logic                 err_eol_q, err_eol_d;

  logic [DATA_W-1:0]    lb0_q [0:MAX_WIDTH-1];
  logic [DATA_W-1:0]    lb1_q [0:MAX_WIDTH-1];

  logic                 s_accept;
  logic                 pix_take;
  logic [CNT_W-1:0]     c_eff;
  logic [1:0]           r_eff;
  logic [CNT_W-1:0]     w_eff;
  logic [AW-1:0]        lb_addr;
  logic [DATA_W-1:0]    top_px;
  logic [DATA_W-1:0]    mid_px;
  logic                 last_col;
  logic                 wrap;

  function automatic logic [CNT_W-1:0] clamp_width(input logic [CNT_W-1:0] lw);
    if (lw < CNT_W'(3)) begin
      return CNT_W'(3);
    end else if (lw > CNT_W'(MAX_WIDTH)) begin
      return CNT_W'(MAX_WIDTH);
    end else begin
      return lw;
    end
  endfunction

  assign s_ready  = !m_valid_q || m_ready;
  assign s_accept = s_valid && s_ready;
  // An accepted SOF restarts the frame at (0,0) with a freshly sampled width, whatever the state.
  assign pix_take = s_accept && (s_sof || (state_q != IDLE));
  assign c_eff    = s_sof ? '0 : col_q;
  assign r_eff    = s_sof ? 2'd0 : row_q;
  assign w_eff    = s_sof ? clamp_width(line_width) : w_q;
  assign lb_addr  = c_eff[AW-1:0];
  assign top_px   = lb1_q[lb_addr];
  assign mid_px   = lb0_q[lb_addr];
  assign last_col = (c_eff == (w_eff - CNT_W'(1)));

`ifdef SOBEL_WIN_EOL_CHECK_EN
  assign wrap = last_col || s_eol;
`else
  logic eol_unused;
  assign eol_unused = s_eol;
  assign wrap       = last_col;
`endif

  // Next-state for position counters, window shift register, output flags and error flag.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    w_d        = w_q;
    m_valid_d  = m_valid_q;
    m_eol_d    = m_eol_q;
    m_window_d = m_window_q;
    err_eol_d  = err_eol_q;
    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
      m_eol_d   = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
    if (pix_take) begin
      w_d = w_eff;
      for (int r = 0; r < 3; r++) begin
        m_window_d[(3*r)*DATA_W +: DATA_W]   = m_window_q[(3*r+1)*DATA_W +: DATA_W];
        m_window_d[(3*r+1)*DATA_W +: DATA_W] = m_window_q[(3*r+2)*DATA_W +: DATA_W];
      end
      m_window_d[2*DATA_W +: DATA_W] = top_px;
      m_window_d[5*DATA_W +: DATA_W] = mid_px;
      m_window_d[8*DATA_W +: DATA_W] = s_data;
      // Only fully interior windows are emitted; the newest pixel is the bottom-right corner.
      m_valid_d = (r_eff == 2'd2) && (c_eff >= CNT_W'(2));
      m_eol_d   = m_valid_d && last_col;
      if (wrap) begin
        col_d = '0;
        row_d = (r_eff == 2'd2) ? 2'd2 : (r_eff + 2'd1);
      end else begin
        col_d = c_eff + CNT_W'(1);
        row_d = r_eff;
      end
      state_d = (row_d == 2'd2) ? RUN : FILL;
`ifdef SOBEL_WIN_EOL_CHECK_EN
      err_eol_d = err_eol_q || (s_eol != last_col);
`else
      err_eol_d = 1'b0;
`endif
    end else begin
      state_d = state_q;
    end
  end

  // Control and output registers.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= 2'd0;
      w_q        <= CNT_W'(3);
      m_valid_q  <= 1'b0;
      m_eol_q    <= 1'b0;
      m_window_q <= '0;
      err_eol_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      w_q        <= w_d;
      m_valid_q  <= m_valid_d;
      m_eol_q    <= m_eol_d;
      m_window_q <= m_window_d;
      err_eol_q  <= err_eol_d;
    end
  end

  // Line buffers: lb0 holds the previous line, lb1 the one before; contents are never reset.
  always_ff @(posedge s00_axi_aclk) begin
    if (pix_take) begin
      lb1_q[lb_addr] <= mid_px;
      lb0_q[lb_addr] <= s_data;
    end
  end

  assign m_valid  = m_valid_q;
  assign m_eol    = m_eol_q;
  assign m_window = m_window_q;
  assign err_eol  = err_eol_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed self-checking bench for sobel_window_gen (default and SOBEL_WIN_EOL_CHECK_EN builds).
module tb_sobel_window_gen;

  localparam int DW = 8;
  localparam int WW = 9 * DW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [10:0]     line_width = 11'd5;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [DW-1:0]   s_data = '0;
  logic            s_sof = 1'b0;
  logic            s_eol = 1'b0;
  logic            m_valid;
  logic            m_ready = 1'b1;
  logic [WW-1:0]   m_window;
  logic            m_eol;
  logic            err_eol;

  int errors = 0;
  int checks = 0;

  logic [WW-1:0] win_q [$];
  logic          eol_q [$];

  sobel_window_gen #(.DATA_W(8), .MAX_WIDTH(1024), .CNT_W(11)) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .line_width      (line_width),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_data          (s_data),
    .s_sof           (s_sof),
    .s_eol           (s_eol),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_window        (m_window),
    .m_eol           (m_eol),
    .err_eol         (err_eol)
  );

  always #5 clk = ~clk;

  // Capture windows on the opposite edge; a transfer happens at the following rising edge.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      win_q.push_back(m_window);
      eol_q.push_back(m_eol);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [WW-1:0] win_model(input int base, input int w, input int r, input int c);
    logic [WW-1:0] v;
    v = '0;
    for (int k = 0; k < 9; k++)
      v[k*DW +: DW] = DW'(base + (r - 2 + k / 3) * w + (c - 2 + k % 3));
    return v;
  endfunction

  task automatic send_px(input int d, input logic sof, input logic eol);
    int n;
    s_data = DW'(d); s_sof = sof; s_eol = eol; s_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) check_eq("s_ready_timeout", WW'(s_ready), WW'(1'b1));
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
  endtask

  task automatic send_frame(input int w, input int h, input int base);
    for (int i = 0; i < w * h; i++)
      send_px(base + i, (i == 0), ((i % w) == w - 1));
  endtask

  task automatic drain();
    repeat (6) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input int w, input int h, input int base);
    int nw;
    nw = (w - 2) * (h - 2);
    check_eq({tag, "_count"}, WW'(win_q.size()), WW'(nw));
    for (int i = 0; i < nw && i < win_q.size(); i++) begin
      check_eq($sformatf("%s_win%0d", tag, i), win_q[i],
               win_model(base, w, 2 + i / (w - 2), 2 + i % (w - 2)));
      check_eq($sformatf("%s_eol%0d", tag, i), WW'(eol_q[i]), WW'((i % (w - 2)) == (w - 3)));
    end
  endtask

  initial begin
    logic [WW-1:0] exp_first;
    logic [WW-1:0] held;
    int n;
    exp_first = {8'd12, 8'd11, 8'd10, 8'd7, 8'd6, 8'd5, 8'd2, 8'd1, 8'd0};

    repeat (3) @(negedge clk);
    check_eq("rst_m_valid", WW'(m_valid), WW'(1'b0));
    check_eq("rst_m_eol", WW'(m_eol), WW'(1'b0));
    check_eq("rst_m_window", m_window, '0);
    check_eq("rst_err_eol", WW'(err_eol), WW'(1'b0));
    check_eq("rst_s_ready", WW'(s_ready), WW'(1'b1));
    @(posedge clk); #1; rst_n = 1'b1;

    // IDLE: pixels without SOF are swallowed
    for (int i = 0; i < 20; i++) send_px(i, 1'b0, 1'b0);
    drain();
    check_eq("idle_no_out", WW'(win_q.size()), WW'(0));

    // Basic 5x5 frame
    line_width = 11'd5;
    for (int i = 0; i < 25; i++) begin
      send_px(i, (i == 0), ((i % 5) == 4));
      if (i == 11) check_eq("basic_none_before_12", WW'(win_q.size()), WW'(0));
    end
    drain();
    if (win_q.size() > 0) check_eq("basic_first", win_q[0], exp_first);
    check_frame("basic", 5, 5, 0);
    win_q.delete(); eol_q.delete();

    // Backpressure on the first window
    m_ready = 1'b0;
    fork
      send_frame(5, 5, 0);
      begin
        n = 0;
        while (!m_valid && n < 400) begin
          @(negedge clk);
          n++;
        end
        check_eq("stall_m_valid", WW'(m_valid), WW'(1'b1));
        held = m_window;
        check_eq("stall_first", held, exp_first);
        repeat (3) begin
          @(negedge clk);
          check_eq("stall_s_ready", WW'(s_ready), WW'(1'b0));
          check_eq("stall_hold", m_window, held);
        end
        @(posedge clk); #1; m_ready = 1'b1;
      end
    join
    drain();
    check_frame("stall", 5, 5, 0);
    win_q.delete(); eol_q.delete();

    // line_width below minimum clamps to 3
    line_width = 11'd2;
    send_frame(3, 3, 0);
    drain();
    check_eq("w3_count", WW'(win_q.size()), WW'(1));
    if (win_q.size() > 0) begin
      check_eq("w3_win", win_q[0], {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0});
      check_eq("w3_eol", WW'(eol_q[0]), WW'(1'b1));
    end
    win_q.delete(); eol_q.delete();

    // SOF restart in the middle of a frame
    line_width = 11'd5;
    for (int i = 0; i < 7; i++) send_px(i, (i == 0), ((i % 5) == 4));
    for (int i = 0; i < 25; i++) begin
      send_px(100 + i, (i == 0), ((i % 5) == 4));
      if (i == 11) check_eq("resof_none_before_12", WW'(win_q.size()), WW'(0));
    end
    drain();
    check_frame("resof", 5, 5, 100);
    win_q.delete(); eol_q.delete();

`ifdef SOBEL_WIN_EOL_CHECK_EN
    // Early s_eol at column 3 forces a wrap and flags the error
    send_px(0, 1'b1, 1'b0); send_px(1, 1'b0, 1'b0); send_px(2, 1'b0, 1'b0); send_px(3, 1'b0, 1'b1);
    check_eq("eolchk_err_set", WW'(err_eol), WW'(1'b1));
    for (int r = 1; r < 5; r++)
      for (int c = 0; c < 5; c++) send_px(10 * r + c, 1'b0, (c == 4));
    drain();
    check_eq("eolchk_err_sticky", WW'(err_eol), WW'(1'b1));
    check_eq("eolchk_count", WW'(win_q.size()), WW'(9));
    if (win_q.size() > 0)
      check_eq("eolchk_first", win_q[0], {8'd22, 8'd21, 8'd20, 8'd12, 8'd11, 8'd10, 8'd2, 8'd1, 8'd0});
`else
    // Without the check, a stray s_eol is ignored
    for (int i = 0; i < 25; i++) send_px(i, (i == 0), ((i % 5) == 4) || (i == 3));
    drain();
    check_eq("eolign_err", WW'(err_eol), WW'(1'b0));
    check_frame("eolign", 5, 5, 0);
`endif
    win_q.delete(); eol_q.delete();

    // Reset mid-frame with a window pending
    m_ready = 1'b0;
    for (int i = 0; i < 13; i++) send_px(i, (i == 0), ((i % 5) == 4));
    @(negedge clk);
    check_eq("prerst_m_valid", WW'(m_valid), WW'(1'b1));
    @(posedge clk); #2; rst_n = 1'b0;
    #1;
    check_eq("midrst_m_valid", WW'(m_valid), WW'(1'b0));
    check_eq("midrst_m_window", m_window, '0);
    check_eq("midrst_err_eol", WW'(err_eol), WW'(1'b0));
    @(posedge clk); #1; rst_n = 1'b1; m_ready = 1'b1;
    win_q.delete(); eol_q.delete();
    for (int i = 13; i < 25; i++) send_px(i, 1'b0, ((i % 5) == 4));
    drain();
    check_eq("postrst_no_out", WW'(win_q.size()), WW'(0));
    send_frame(5, 5, 50);
    drain();
    check_frame("postrst", 5, 5, 50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
